apb_pvt_sensor: RTL and testbench

//  APB3 slave hosting NO_OF_GROUPS register groups; group g contains process (P), voltage (V) and

---
 rtl/pvt_pkg.sv | 38 +++
 rtl/pvt_sensor_model.sv | 87 ++++++++
 rtl/apb_pvt_sensor.sv | 148 ++++++++++++++
 tb/tb_apb_pvt_sensor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pvt_pkg.sv
// Shared definitions for the APB PVT sensor block: register map offsets, bit positions,
// sensor FSM states and the saturating result helper.
package pvt_pkg;

  localparam int RES_W = 10;
  localparam logic [RES_W-1:0] RES_MAX = '1;

  // Word offsets inside a four-word register group.
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_TCAL   = 2'd2;
  localparam logic [1:0] OFF_DATA   = 2'd3;

  localparam int CTRL_P_EN = 0;
  localparam int CTRL_V_EN = 1;
  localparam int CTRL_T_EN = 2;

  localparam int STATUS_VALID_LSB   = 0;
  localparam int STATUS_PRESENT_LSB = 16;

  localparam int DATA_P_LSB = 0;
  localparam int DATA_V_LSB = 10;
  localparam int DATA_T_LSB = 20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_CONV  = 2'd2
  } sensor_state_e;

  function automatic logic [RES_W-1:0] sat_add(input logic [RES_W-1:0] a,
                                               input logic [RES_W-1:0] b);
    logic [RES_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[RES_W] ? RES_MAX : sum[RES_W-1:0];
  endfunction

endpackage

// File: rtl/pvt_sensor_model.sv
// Behavioural model of one P, V or T sensor: counts enabled cycles, then after a fixed
// conversion latency publishes min(count + offset, max) with a valid flag.
module pvt_sensor_model
  import pvt_pkg::*;
#(
  parameter int SENSOR_LATENCY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [RES_W-1:0] offset_i,
  output logic             valid_o,
  output logic [RES_W-1:0] result_o
);

  localparam int TW = $clog2(SENSOR_LATENCY + 1);
  localparam logic [TW-1:0] LAT = TW'(SENSOR_LATENCY);

  sensor_state_e    state_q, state_d;
  logic [RES_W-1:0] count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             valid_q, valid_d;
  logic [RES_W-1:0] result_q, result_d;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    timer_d  = timer_q;
    valid_d  = valid_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_COUNT;
          count_d = '0;
          valid_d = 1'b0;
        end
      end
      S_COUNT: begin
        if (en_i) begin
          if (count_q != RES_MAX) count_d = count_q + 1'b1;
        end else begin
          state_d = S_CONV;
          timer_d = LAT;
        end
      end
      S_CONV: begin
        if (en_i) begin
          // Re-enable mid-conversion discards the pending result and restarts counting.
          state_d = S_COUNT;
          count_d = '0;
          valid_d = 1'b0;
        end else if (timer_q <= TW'(1)) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          result_d = sat_add(count_q, offset_i);
          valid_d  = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      timer_q  <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: rtl/apb_pvt_sensor.sv
// APB3 slave exposing NO_OF_GROUPS CTRL/STATUS/TCAL/DATA register groups over PVT sensor models.
// Define APB_WAIT_STATE_EN to insert one wait state into every access phase.
module apb_pvt_sensor
  import pvt_pkg::*;
#(
  parameter int NO_OF_PSENSORS = 10,
  parameter int NO_OF_VSENSORS = 4,
  parameter int NO_OF_TSENSORS = 8,
  parameter int NO_OF_GROUPS   = 10,
  parameter int SENSOR_LATENCY = 8,
  localparam int AW = $clog2(NO_OF_GROUPS * 4)
) (
  input  logic          s_apb_clk,
  input  logic          s_apb_rstn,
  input  logic [AW+1:0] s_apb_addr,
  input  logic          s_apb_sel,
  input  logic          s_apb_enable,
  input  logic          s_apb_write,
  input  logic [31:0]   s_apb_wdata,
  input  logic [3:0]    s_apb_wstrb,
  output logic [31:0]   s_apb_rdata,
  output logic          s_apb_ready,
  output logic          s_apb_slverr
);

  localparam int GW = AW - 2;

  logic [AW-1:0] word;
  logic [GW-1:0] group;
  logic [1:0]    offset;
  logic          access, in_range, err, wr_en;
  logic [31:0]   rd_word;
  logic          unused_ok;

  assign word      = s_apb_addr[AW+1:2];
  assign group     = word[AW-1:2];
  assign offset    = word[1:0];
  assign access    = s_apb_sel & s_apb_enable;
  assign in_range  = {1'b0, word} < (AW + 1)'(NO_OF_GROUPS * 4);
  assign err       = ~in_range | (s_apb_write & ((offset == OFF_STATUS) | (offset == OFF_DATA)));
  assign unused_ok = ^{s_apb_wstrb, s_apb_addr[1:0]};

`ifdef APB_WAIT_STATE_EN
  logic wait_q, wait_d;

  assign wait_d      = access & ~wait_q;
  assign s_apb_ready = access & wait_q;

  always_ff @(posedge s_apb_clk or negedge s_apb_rstn) begin
    if (!s_apb_rstn) wait_q <= 1'b0;
    else             wait_q <= wait_d;
  end
`else
  assign s_apb_ready = access;
`endif

  assign wr_en        = access & s_apb_ready & s_apb_write & ~err;
  assign s_apb_slverr = access & err;
  assign s_apb_rdata  = (access & ~err & ~s_apb_write) ? rd_word : 32'h0;

  logic [31:0] ctrl_q [NO_OF_GROUPS];
  logic [31:0] ctrl_d [NO_OF_GROUPS];
  logic [31:0] tcal_q [NO_OF_GROUPS];
  logic [31:0] tcal_d [NO_OF_GROUPS];

  always_comb begin
    ctrl_d = ctrl_q;
    tcal_d = tcal_q;
    for (int g = 0; g < NO_OF_GROUPS; g++) begin
      if (wr_en && group == GW'(g)) begin
        if (offset == OFF_CTRL) ctrl_d[g] = s_apb_wdata;
        if (offset == OFF_TCAL) tcal_d[g] = s_apb_wdata;
      end
    end
  end

  // NOTE: the register arrays are ordinary flops with an observable reset value, so they are
  // reset explicitly rather than left to power-up state like a RAM.
  always_ff @(posedge s_apb_clk or negedge s_apb_rstn) begin
    if (!s_apb_rstn) begin
      for (int g = 0; g < NO_OF_GROUPS; g++) begin
        ctrl_q[g] <= '0;
        tcal_q[g] <= '0;
      end
    end else begin
      ctrl_q <= ctrl_d;
      tcal_q <= tcal_d;
    end
  end

  logic [NO_OF_GROUPS-1:0] p_valid, v_valid, t_valid;
  logic [RES_W-1:0]        p_res [NO_OF_GROUPS];
  logic [RES_W-1:0]        v_res [NO_OF_GROUPS];
  logic [RES_W-1:0]        t_res [NO_OF_GROUPS];

  for (genvar g = 0; g < NO_OF_GROUPS; g++) begin : g_grp
    if (g < NO_OF_PSENSORS) begin : g_p
      pvt_sensor_model #(.SENSOR_LATENCY(SENSOR_LATENCY)) u_sensor (
        .clk(s_apb_clk), .rst_n(s_apb_rstn), .en_i(ctrl_q[g][CTRL_P_EN]),
        .offset_i({RES_W{1'b0}}), .valid_o(p_valid[g]), .result_o(p_res[g]));
    end else begin : g_p_absent
      assign p_valid[g] = 1'b0;
      assign p_res[g]   = '0;
    end

    if (g < NO_OF_VSENSORS) begin : g_v
      pvt_sensor_model #(.SENSOR_LATENCY(SENSOR_LATENCY)) u_sensor (
        .clk(s_apb_clk), .rst_n(s_apb_rstn), .en_i(ctrl_q[g][CTRL_V_EN]),
        .offset_i({RES_W{1'b0}}), .valid_o(v_valid[g]), .result_o(v_res[g]));
    end else begin : g_v_absent
      assign v_valid[g] = 1'b0;
      assign v_res[g]   = '0;
    end

    // Only the temperature path applies the TCAL offset.
    if (g < NO_OF_TSENSORS) begin : g_t
      pvt_sensor_model #(.SENSOR_LATENCY(SENSOR_LATENCY)) u_sensor (
        .clk(s_apb_clk), .rst_n(s_apb_rstn), .en_i(ctrl_q[g][CTRL_T_EN]),
        .offset_i(tcal_q[g][RES_W-1:0]), .valid_o(t_valid[g]), .result_o(t_res[g]));
    end else begin : g_t_absent
      assign t_valid[g] = 1'b0;
      assign t_res[g]   = '0;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int g = 0; g < NO_OF_GROUPS; g++) begin
      if (group == GW'(g)) begin
        case (offset)
          OFF_CTRL: rd_word = ctrl_q[g];
          OFF_STATUS: begin
            rd_word[STATUS_VALID_LSB +: 3]   = {t_valid[g], v_valid[g], p_valid[g]};
            rd_word[STATUS_PRESENT_LSB +: 3] = {g < NO_OF_TSENSORS, g < NO_OF_VSENSORS,
                                                g < NO_OF_PSENSORS};
          end
          OFF_TCAL: rd_word = tcal_q[g];
          default: begin
            rd_word[DATA_P_LSB +: RES_W] = p_res[g];
            rd_word[DATA_V_LSB +: RES_W] = v_res[g];
            rd_word[DATA_T_LSB +: RES_W] = t_res[g];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_pvt_sensor.sv
// Directed self-checking bench for apb_pvt_sensor with the default parameter set
// (10 groups, P in 0..9, V in 0..3, T in 0..7, latency 8).
module tb_apb_pvt_sensor;

`ifdef APB_WAIT_STATE_EN
  localparam int   ACC         = 3;     // edges from setup start to completing edge
  localparam logic FIRST_READY = 1'b0;
`else
  localparam int   ACC         = 2;
  localparam logic FIRST_READY = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pwstrb = 4'hF;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int w1, w2, w3, w4;

  apb_pvt_sensor dut (
    .s_apb_clk(clk), .s_apb_rstn(rstn), .s_apb_addr(paddr), .s_apb_sel(psel),
    .s_apb_enable(penable), .s_apb_write(pwrite), .s_apb_wdata(pwdata),
    .s_apb_wstrb(pwstrb), .s_apb_rdata(prdata), .s_apb_ready(pready),
    .s_apb_slverr(pslverr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One APB transfer; returns the read data and slverr seen on the completing cycle.
  task automatic apb_xfer(input string tag, input logic wr, input logic [7:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check({tag, "_ready1"}, {31'b0, pready}, {31'b0, FIRST_READY});
    n = 0;
    while (!pready && n < 4) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'b0, pready}, 32'd1);
    rd = prdata;
    er = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                        input logic exp_e);
    logic [31:0] d;
    logic        e;
    apb_xfer(tag, 1'b0, a, 32'h0, d, e);
    check({tag, "_rdata"}, d, exp_d);
    check({tag, "_slverr"}, {31'b0, e}, {31'b0, exp_e});
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] wd,
                        input logic exp_e);
    logic [31:0] d;
    logic        e;
    apb_xfer(tag, 1'b1, a, wd, d, e);
    check({tag, "_slverr"}, {31'b0, e}, {31'b0, exp_e});
  endtask

  initial begin
    // Reset: idle bus outputs are zero, every group 0 register reads zero except PRESENT.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", prdata, 32'h0);
    check("rst_ready", {31'b0, pready}, 32'd0);
    check("rst_slverr", {31'b0, pslverr}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_ctrl0",   8'h00, 32'h0000_0000, 1'b0);
    rd_chk("rst_status0", 8'h04, 32'h0007_0000, 1'b0);
    rd_chk("rst_tcal0",   8'h08, 32'h0000_0000, 1'b0);
    rd_chk("rst_data0",   8'h0C, 32'h0000_0000, 1'b0);

    // A setup phase that is never followed by an access phase must not write.
    psel = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    psel = 1'b0; pwrite = 1'b0;
    rd_chk("setup_only", 8'h08, 32'h0000_0000, 1'b0);

    // Group 0: P_EN/V_EN high. The entry edge clears the count, then 20 more edges with
    // EN=1 before CTRL=0 commits give count 20.
    wr_chk("g0_en", 8'h00, 32'h0001_FFC3, 1'b0);
    w1 = cyc;
    rd_chk("g0_ctrl", 8'h00, 32'h0001_FFC3, 1'b0);
    rd_chk("g0_status_cnt", 8'h04, 32'h0007_0000, 1'b0);
    wait_edge(w1 + 21 - ACC);
    wr_chk("g0_dis", 8'h00, 32'h0, 1'b0);
    w2 = cyc;
    wait_edge(w2 + 8 - ACC);                       // samples after edge w2+7
    rd_chk("g0_status_conv", 8'h04, 32'h0007_0000, 1'b0);
    wait_edge(w2 + 12);
    rd_chk("g0_status_done", 8'h04, 32'h0007_0003, 1'b0);
    rd_chk("g0_data", 8'h0C, 32'h0000_5014, 1'b0);

    // Group 5: V absent, T offset 5 -> T = 25, P = 20.
    wr_chk("g5_tcal", 8'h58, 32'hABCD_E005, 1'b0);
    rd_chk("g5_tcal_rb", 8'h58, 32'hABCD_E005, 1'b0);
    wr_chk("g5_en", 8'h50, 32'h0000_0007, 1'b0);
    w1 = cyc;
    wait_edge(w1 + 21 - ACC);
    wr_chk("g5_dis", 8'h50, 32'h0, 1'b0);
    w2 = cyc;
    wait_edge(w2 + 10 - ACC);                      // samples after edge w2+9
    rd_chk("g5_status", 8'h54, 32'h0005_0005, 1'b0);
    rd_chk("g5_data", 8'h5C, 32'h0190_0014, 1'b0);

    // Group 2: T saturates, 5 + 1023 clamps to 1023.
    wr_chk("g2_tcal", 8'h28, 32'h0000_03FF, 1'b0);
    wr_chk("g2_en", 8'h20, 32'h0000_0004, 1'b0);
    w1 = cyc;
    wait_edge(w1 + 6 - ACC);
    wr_chk("g2_dis", 8'h20, 32'h0, 1'b0);
    w2 = cyc;
    wait_edge(w2 + 12);
    rd_chk("g2_status", 8'h24, 32'h0007_0004, 1'b0);
    rd_chk("g2_data", 8'h2C, 32'h3FF0_0000, 1'b0);

    // Group 1: re-enable while converting aborts, then a fresh count of 15.
    wr_chk("g1_en", 8'h10, 32'h0000_0001, 1'b0);
    w1 = cyc;
    wait_edge(w1 + 6 - ACC);
    wr_chk("g1_dis", 8'h10, 32'h0, 1'b0);
    w2 = cyc;
    wr_chk("g1_reen", 8'h10, 32'h0000_0001, 1'b0);
    w3 = cyc;
    wait_edge(w2 + 13 - ACC);                      // past the aborted conversion's deadline
    rd_chk("g1_status_abort", 8'h14, 32'h0007_0000, 1'b0);
    rd_chk("g1_data_abort", 8'h1C, 32'h0000_0000, 1'b0);
    wait_edge(w3 + 16 - ACC);
    wr_chk("g1_dis2", 8'h10, 32'h0, 1'b0);
    w4 = cyc;
    wait_edge(w4 + 12);
    rd_chk("g1_status", 8'h14, 32'h0007_0001, 1'b0);
    rd_chk("g1_data", 8'h1C, 32'h0000_000F, 1'b0);

    // Error responses and address boundaries.
    wr_chk("oor_wr", 8'hB8, 32'hFFFF_FFFF, 1'b1);
    rd_chk("oor_rd", 8'hB8, 32'h0000_0000, 1'b1);
    rd_chk("word40", 8'hA0, 32'h0000_0000, 1'b1);
    rd_chk("word39", 8'h9C, 32'h0000_0000, 1'b0);
    rd_chk("g9_status", 8'h94, 32'h0001_0000, 1'b0);
    wr_chk("ro_status", 8'h04, 32'hFFFF_FFFF, 1'b1);
    wr_chk("ro_data", 8'h5C, 32'h0000_0000, 1'b1);
    rd_chk("ro_status_kept", 8'h04, 32'h0007_0003, 1'b0);
    rd_chk("ro_data_kept", 8'h5C, 32'h0190_0014, 1'b0);
    rd_chk("oor_ctrl0_kept", 8'h00, 32'h0000_0000, 1'b0);
    rd_chk("oor_tcal5_kept", 8'h58, 32'hABCD_E005, 1'b0);

    // Reset during a conversion clears everything and no result appears afterwards.
    wr_chk("g3_en", 8'h30, 32'h0000_0001, 1'b0);
    w1 = cyc;
    wait_edge(w1 + 6 - ACC);
    wr_chk("g3_dis", 8'h30, 32'h0, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    rd_chk("rst_g3_status", 8'h34, 32'h0007_0000, 1'b0);
    rd_chk("rst_g3_data", 8'h3C, 32'h0000_0000, 1'b0);
    rd_chk("rst_g5_tcal", 8'h58, 32'h0000_0000, 1'b0);
    rd_chk("rst_g5_data", 8'h5C, 32'h0000_0000, 1'b0);
    rd_chk("rst_g0_status", 8'h04, 32'h0007_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
